// File: rtl/rv_mem_pkg.sv
// Shared definitions for the memory-stage load/store unit: access-size codes,
// the load result-select value, FSM state encoding and an alignment helper.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // Size comes from funct3[1:0]; every code other than byte/half behaves as a word.
    function automatic logic isMisaligned(input logic [1:0] sizeSel, input logic [1:0] addrLo);
        logic mis;
        case (sizeSel)
            F3_B[1:0]: mis = 1'b0;
            F3_H[1:0]: mis = addrLo[0];
            default:   mis = (addrLo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Picks the addressed byte/halfword out of a bus read word and sign- or
// zero-extends it to 32 bits; word-sized loads pass through untouched.
module load_align_ext
    import rv_mem_pkg::*;
(
    input  logic [31:0] memRData_i,
    input  logic [1:0]  addrLo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] extData_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic        signExt;

    always_comb begin
        case (addrLo_i)
            2'd0:    byteSel = memRData_i[7:0];
            2'd1:    byteSel = memRData_i[15:8];
            2'd2:    byteSel = memRData_i[23:16];
            default: byteSel = memRData_i[31:24];
        endcase
        halfSel = addrLo_i[1] ? memRData_i[31:16] : memRData_i[15:0];
        signExt = ~funct3_i[2];
        case (funct3_i[1:0])
            F3_B[1:0]: extData_o = {{24{signExt & byteSel[7]}}, byteSel};
            F3_H[1:0]: extData_o = {{16{signExt & halfSel[15]}}, halfSel};
            default:   extData_o = memRData_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: issues one req/ack bus transaction per aligned
// access, stalls the pipeline while it is outstanding and aborts on timeout.
module mem_stage_lsu
    import rv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memWriteM,
    input  logic [1:0]  resultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] writeDataM,
    input  logic [31:0] memRData,
    input  logic        memAck,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    output logic [3:0]  memByteEn,
    output logic [31:0] readDataM,
    output logic        stallM,
    output logic        misalignM,
    output logic        busErrM
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cntInc;
    logic             memReq_q, memReq_d;
    logic             memWe_q, memWe_d;
    logic [31:0]      memAddr_q, memAddr_d;
    logic [31:0]      memWData_q, memWData_d;
    logic [3:0]       memByteEn_q, memByteEn_d;
    logic [1:0]       addrLo_q, addrLo_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      readData_q, readData_d;
    logic             misalign_q, misalign_d;
    logic             busErr_q, busErr_d;
    logic             stallRaw;

    logic             isLoad, accessValid, misaligned;
    logic [31:0]      storeData;
    logic [3:0]       storeBe;
    logic [31:0]      loadData;

    assign isLoad      = (resultSrcM == RESULT_SRC_MEM);
    assign accessValid = memWriteM | isLoad;
    assign misaligned  = isMisaligned(funct3M[1:0], ALUResultM[1:0]);
    assign cntInc      = cnt_q + 1'b1;

    always_comb begin
        case (funct3M[1:0])
            F3_B[1:0]: begin
                storeData = {4{writeDataM[7:0]}};
                storeBe   = 4'b0001 << ALUResultM[1:0];
            end
            F3_H[1:0]: begin
                storeData = {2{writeDataM[15:0]}};
                storeBe   = ALUResultM[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                storeData = writeDataM;
                storeBe   = 4'b1111;
            end
        endcase
    end

    // Extension uses the latched address/size so the pipeline may change its inputs freely.
    load_align_ext u_loadAlign (
        .memRData_i (memRData),
        .addrLo_i   (addrLo_q),
        .funct3_i   (funct3_q),
        .extData_o  (loadData)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        memReq_d    = memReq_q;
        memWe_d     = memWe_q;
        memAddr_d   = memAddr_q;
        memWData_d  = memWData_q;
        memByteEn_d = memByteEn_q;
        addrLo_d    = addrLo_q;
        funct3_d    = funct3_q;
        readData_d  = readData_q;
        misalign_d  = 1'b0;
        busErr_d    = 1'b0;
        stallRaw    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accessValid && misaligned) begin
                    misalign_d = 1'b1;
                end else if (accessValid) begin
                    stallRaw    = 1'b1;
                    memReq_d    = 1'b1;
                    memWe_d     = memWriteM;
                    memAddr_d   = {ALUResultM[31:2], 2'b00};
                    memWData_d  = storeData;
                    memByteEn_d = memWriteM ? storeBe : 4'b1111;
                    addrLo_d    = ALUResultM[1:0];
                    funct3_d    = funct3M;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                stallRaw = 1'b1;
                cnt_d    = cntInc;
                // An ack arriving on the timeout cycle still completes normally.
                if (memAck) begin
                    memReq_d = 1'b0;
                    if (!memWe_q) begin
                        readData_d = loadData;
                    end
                    state_d = DONE;
                end else if (cntInc == TIMEOUT_VAL) begin
                    memReq_d   = 1'b0;
                    readData_d = '0;
                    busErr_d   = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            memReq_q    <= 1'b0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memWData_q  <= '0;
            memByteEn_q <= '0;
            addrLo_q    <= '0;
            funct3_q    <= '0;
            readData_q  <= '0;
            misalign_q  <= 1'b0;
            busErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            memReq_q    <= memReq_d;
            memWe_q     <= memWe_d;
            memAddr_q   <= memAddr_d;
            memWData_q  <= memWData_d;
            memByteEn_q <= memByteEn_d;
            addrLo_q    <= addrLo_d;
            funct3_q    <= funct3_d;
            readData_q  <= readData_d;
            misalign_q  <= misalign_d;
            busErr_q    <= busErr_d;
        end
    end

    // The IDLE stall depends on live inputs, so it is masked to keep every output low in reset.
    assign stallM    = rst_n & stallRaw;
    assign memReq    = memReq_q;
    assign memWe     = memWe_q;
    assign memAddr   = memAddr_q;
    assign memWData  = memWData_q;
    assign memByteEn = memByteEn_q;
    assign readDataM = readData_q;
    assign misalignM = misalign_q;
    assign busErrM   = busErr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table, reset corner
// case, then random accesses against a transaction-level reference model.
module tb_mem_stage_lsu;

    localparam int TIMEOUT = 4;

    logic        clk;
    logic        rst_n;
    logic        memWriteM;
    logic [1:0]  resultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] writeDataM;
    logic [31:0] memRData;
    logic        memAck;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [3:0]  memByteEn;
    logic [31:0] readDataM;
    logic        stallM;
    logic        misalignM;
    logic        busErrM;

    int nCompared   = 0;
    int nMismatched = 0;
    logic [31:0] modelRd;

    typedef struct {
        logic        we;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          ackDelay;
        logic        expMis;
        logic [31:0] expRd;
        logic        expErr;
        logic [3:0]  expBe;
        logic [31:0] expWData;
        int          expStall;
    } vec_t;

    vec_t vecs[16];

    mem_stage_lsu #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .memWriteM  (memWriteM),
        .resultSrcM (resultSrcM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .writeDataM (writeDataM),
        .memRData   (memRData),
        .memAck     (memAck),
        .memReq     (memReq),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memWData   (memWData),
        .memByteEn  (memByteEn),
        .readDataM  (readDataM),
        .stallM     (stallM),
        .misalignM  (misalignM),
        .busErrM    (busErrM)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        memWriteM  = 1'b0;
        resultSrcM = 2'b00;
        funct3M    = 3'b000;
        ALUResultM = 32'h0;
        writeDataM = 32'h0;
        memRData   = 32'h0;
        memAck     = 1'b0;
    endtask

    function automatic int sizeBytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Reference load: shift the addressed item down, mask, then extend arithmetically.
    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rdata);
        int          loInt;
        int          bytes;
        logic [31:0] v;
        loInt = int'(lo);
        bytes = sizeBytes(f3);
        if (bytes == 1) begin
            v = (rdata >> (8 * loInt)) & 32'hFF;
            if (!f3[2] && v >= 32'd128) v = v - 32'd256;
        end else if (bytes == 2) begin
            v = (rdata >> (16 * (loInt / 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    // Runs one M-stage instruction from IDLE through to the following IDLE cycle.
    task automatic applyStimulus(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                                 input int ackDelay, input logic expMis, input logic [31:0] expRd,
                                 input logic expErr, input logic [3:0] expBe, input logic [31:0] expWData,
                                 input int expStall, input string tag);
        int   stalls;
        logic valid;
        memWriteM  = we;
        resultSrcM = rs;
        funct3M    = f3;
        ALUResultM = addr;
        writeDataM = wd;
        memRData   = rdata;
        memAck     = 1'b0;
        #1;
        valid  = we || (rs == 2'b01);
        stalls = (stallM === 1'b1) ? 1 : 0;
        if (!valid || expMis) begin
            checkOutput({tag, ".idleStall"}, 32'(stallM), 32'd0);
            step();
            checkOutput({tag, ".misalign"}, 32'(misalignM), 32'(expMis));
            checkOutput({tag, ".noReq"}, 32'(memReq), 32'd0);
            checkOutput({tag, ".readData"}, readDataM, expRd);
            setIdle();
            return;
        end
        step();
        for (int k = 1; k <= TIMEOUT; k++) begin
            checkOutput({tag, ".req"}, 32'(memReq), 32'd1);
            checkOutput({tag, ".addr"}, memAddr, addr & 32'hFFFF_FFFC);
            checkOutput({tag, ".be"}, 32'(memByteEn), 32'(expBe));
            checkOutput({tag, ".we"}, 32'(memWe), 32'(we));
            if (we) checkOutput({tag, ".wdata"}, memWData, expWData);
            stalls += (stallM === 1'b1) ? 1 : 0;
            if (k == ackDelay) memAck = 1'b1;
            step();
            memAck = 1'b0;
            if (k == ackDelay) break;
        end
        setIdle();
        #1;
        stalls += (stallM === 1'b1) ? 1 : 0;
        checkOutput({tag, ".doneStall"}, 32'(stallM), 32'd0);
        checkOutput({tag, ".doneReq"}, 32'(memReq), 32'd0);
        checkOutput({tag, ".readData"}, readDataM, expRd);
        checkOutput({tag, ".busErr"}, 32'(busErrM), 32'(expErr));
        checkOutput({tag, ".stallCycles"}, 32'(stalls), 32'(expStall));
        step();
        checkOutput({tag, ".busErrPulse"}, 32'(busErrM), 32'd0);
    endtask

    initial begin
        int   loInt;
        int   bytes;
        int   beInt;
        int   ackDelay;
        logic we;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic valid;
        logic mis;
        logic expErr;
        int   expStall;
        logic [3:0]  expBe;
        logic [31:0] expW;

        //          we    rs     f3      addr          wd            rdata         ack mis  expRd         err  be       wdata         stall
        vecs[0]  = '{1'b0, 2'b01, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 1, 1'b0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,        2};
        vecs[1]  = '{1'b0, 2'b01, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF7F01, 1, 1'b0, 32'hFFFFFF80, 1'b0, 4'b1111, 32'h0,        2};
        vecs[2]  = '{1'b0, 2'b01, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF7F01, 1, 1'b0, 32'h00000080, 1'b0, 4'b1111, 32'h0,        2};
        vecs[3]  = '{1'b1, 2'b00, 3'b001, 32'h0000_0206, 32'h1234ABCD, 32'h0,        1, 1'b0, 32'h00000080, 1'b0, 4'b1100, 32'hABCDABCD, 2};
        vecs[4]  = '{1'b0, 2'b01, 3'b010, 32'h0000_0102, 32'h0,        32'h11111111, 1, 1'b1, 32'h00000080, 1'b0, 4'b1111, 32'h0,        0};
        vecs[5]  = '{1'b0, 2'b01, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF7F01, 3, 1'b0, 32'hFFFF80FF, 1'b0, 4'b1111, 32'h0,        4};
        vecs[6]  = '{1'b0, 2'b01, 3'b101, 32'h0000_0101, 32'h0,        32'h22222222, 1, 1'b1, 32'hFFFF80FF, 1'b0, 4'b1111, 32'h0,        0};
        vecs[7]  = '{1'b1, 2'b00, 3'b000, 32'h0000_0301, 32'h000000A5, 32'h0,        2, 1'b0, 32'hFFFF80FF, 1'b0, 4'b0010, 32'hA5A5A5A5, 3};
        vecs[8]  = '{1'b0, 2'b01, 3'b010, 32'h0000_0400, 32'h0,        32'h33333333, 0, 1'b0, 32'h00000000, 1'b1, 4'b1111, 32'h0,        5};
        vecs[9]  = '{1'b0, 2'b01, 3'b011, 32'h0000_0404, 32'h0,        32'h12345678, 4, 1'b0, 32'h12345678, 1'b0, 4'b1111, 32'h0,        5};
        vecs[10] = '{1'b1, 2'b01, 3'b010, 32'h0000_0500, 32'hCAFEF00D, 32'h44444444, 1, 1'b0, 32'h12345678, 1'b0, 4'b1111, 32'hCAFEF00D, 2};
        vecs[11] = '{1'b0, 2'b10, 3'b010, 32'h0000_0102, 32'h0,        32'h55555555, 1, 1'b0, 32'h12345678, 1'b0, 4'b1111, 32'h0,        0};
        vecs[12] = '{1'b0, 2'b01, 3'b101, 32'h0000_0102, 32'h0,        32'h80010000, 2, 1'b0, 32'h00008001, 1'b0, 4'b1111, 32'h0,        3};
        vecs[13] = '{1'b0, 2'b01, 3'b110, 32'h0000_0206, 32'h0,        32'h66666666, 1, 1'b1, 32'h00008001, 1'b0, 4'b1111, 32'h0,        0};
        vecs[14] = '{1'b1, 2'b00, 3'b010, 32'h0000_0600, 32'h11223344, 32'h0,        0, 1'b0, 32'h00000000, 1'b1, 4'b1111, 32'h11223344, 5};
        vecs[15] = '{1'b0, 2'b01, 3'b000, 32'h0000_0100, 32'h0,        32'h0000007F, 1, 1'b0, 32'h0000007F, 1'b0, 4'b1111, 32'h0,        2};

        setIdle();
        rst_n = 1'b0;
        step();
        step();
        checkOutput("reset.memReq", 32'(memReq), 32'd0);
        checkOutput("reset.memWe", 32'(memWe), 32'd0);
        checkOutput("reset.memAddr", memAddr, 32'd0);
        checkOutput("reset.memWData", memWData, 32'd0);
        checkOutput("reset.memByteEn", 32'(memByteEn), 32'd0);
        checkOutput("reset.readDataM", readDataM, 32'd0);
        checkOutput("reset.stallM", 32'(stallM), 32'd0);
        checkOutput("reset.misalignM", 32'(misalignM), 32'd0);
        checkOutput("reset.busErrM", 32'(busErrM), 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].we, vecs[i].rs, vecs[i].f3, vecs[i].addr, vecs[i].wd, vecs[i].rdata,
                          vecs[i].ackDelay, vecs[i].expMis, vecs[i].expRd, vecs[i].expErr,
                          vecs[i].expBe, vecs[i].expWData, vecs[i].expStall, $sformatf("vec%0d", i));
        end

        // Reset asserted while a load is outstanding, then a stray ack with nothing pending.
        memWriteM  = 1'b0;
        resultSrcM = 2'b01;
        funct3M    = 3'b010;
        ALUResultM = 32'h0000_0700;
        step();
        checkOutput("rstBusy.reqBefore", 32'(memReq), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstBusy.memReqAsync", 32'(memReq), 32'd0);
        checkOutput("rstBusy.stallAsync", 32'(stallM), 32'd0);
        step();
        setIdle();
        rst_n  = 1'b1;
        memAck = 1'b1;
        step();
        step();
        checkOutput("strayAck.memReq", 32'(memReq), 32'd0);
        checkOutput("strayAck.stallM", 32'(stallM), 32'd0);
        checkOutput("strayAck.readDataM", readDataM, 32'd0);
        checkOutput("strayAck.busErrM", 32'(busErrM), 32'd0);
        memAck  = 1'b0;
        modelRd = 32'h0;

        for (int n = 0; n < 60; n++) begin
            we       = ($urandom_range(0, 2) == 0);
            rs       = 2'($urandom_range(0, 3));
            f3       = 3'($urandom_range(0, 7));
            addr     = $urandom;
            wd       = $urandom;
            rdata    = $urandom;
            ackDelay = $urandom_range(0, 5);
            loInt    = int'(addr[1:0]);
            bytes    = sizeBytes(f3);
            valid    = we || (rs == 2'b01);
            mis      = valid && ((loInt % bytes) != 0);
            expErr   = 1'b0;
            expStall = 0;
            expBe    = 4'hF;
            expW     = wd;
            if (valid && !mis) begin
                if (ackDelay >= 1 && ackDelay <= TIMEOUT) begin
                    expStall = 1 + ackDelay;
                end else begin
                    expStall = 1 + TIMEOUT;
                    expErr   = 1'b1;
                end
                if (expErr) modelRd = 32'h0;
                else if (!we) modelRd = modelLoad(f3, addr[1:0], rdata);
                if (we) begin
                    beInt = ((1 << bytes) - 1) << loInt;
                    expBe = beInt[3:0];
                    if (bytes == 1) expW = {24'b0, wd[7:0]} * 32'h01010101;
                    else if (bytes == 2) expW = {16'b0, wd[15:0]} * 32'h00010001;
                end
            end
            applyStimulus(we, rs, f3, addr, wd, rdata, ackDelay, mis, modelRd, expErr,
                          expBe, expW, expStall, $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
